// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and the LSU.
// Optional fetch anti-starvation guard: define ARB_STARVE_GUARD_EN.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [DATA_W/8-1:0] ls_be,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    if (MEM_LAT < 1 || STARVE_MAX < 1 || (DATA_W % 8) != 0) begin : g_bad_cfg
        $error("mem_bus_arbiter: invalid parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [LAT_W-1:0]   lat_cnt_r;
    logic               sel_ls_r;
    logic               arb_s;
    logic               win_ls_s;
    logic               starve_hit_s;
    logic               cap_s;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] starve_cnt_r;

    assign starve_hit_s = if_req && (starve_cnt_r == CNT_W'(STARVE_MAX));

    // Counts LSU wins while fetch is waiting; saturates at STARVE_MAX
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (!if_req) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (arb_s && !win_ls_s) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (arb_s && win_ls_s && (starve_cnt_r != CNT_W'(STARVE_MAX))) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    assign starve_hit_s = 1'b0;
`endif

    assign arb_s    = ((state_r == ST_IDLE) || (state_r == ST_RESP)) && (ls_req || if_req);
    assign win_ls_s = ls_req && !starve_hit_s;
    assign cap_s    = (state_r == ST_WAIT) && (lat_cnt_r == LAT_W'(0));
    assign busy     = (state_r != ST_IDLE);

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_RESP: begin
                if (arb_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_we) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_r == LAT_W'(0)) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, latency counter and memory-side registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r   <= ST_IDLE;
            lat_cnt_r <= LAT_W'(0);
            sel_ls_r  <= 1'b0;
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= {(DATA_W/8){1'b0}};
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_s;
            if_gnt  <= arb_s && !win_ls_s;
            ls_gnt  <= arb_s && win_ls_s;
            mem_en  <= arb_s;
            // The memory registers double as the winner's request latch
            if (arb_s) begin
                sel_ls_r  <= win_ls_s;
                mem_we    <= win_ls_s && ls_we;
                mem_be    <= (win_ls_s && ls_we) ? ls_be : {(DATA_W/8){1'b1}};
                mem_addr  <= win_ls_s ? ls_addr : if_addr;
                mem_wdata <= win_ls_s ? ls_wdata : mem_wdata;
            end else begin
                mem_we <= 1'b0;
            end
            if ((state_r == ST_ISSUE) && (state_s == ST_WAIT)) begin
                lat_cnt_r <= LAT_W'(MEM_LAT - 1);
            end else if ((state_r == ST_WAIT) && (lat_cnt_r != LAT_W'(0))) begin
                lat_cnt_r <= lat_cnt_r - LAT_W'(1);
            end else begin
                lat_cnt_r <= lat_cnt_r;
            end
        end
    end

    // Read-response capture; rdata holds until the next capture for that port
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            if_rdata  <= {DATA_W{1'b0}};
            ls_rdata  <= {DATA_W{1'b0}};
        end else begin
            if_rvalid <= cap_s && !sel_ls_r;
            ls_rvalid <= cap_s && sel_ls_r;
            if (cap_s && sel_ls_r) begin
                ls_rdata <= mem_rdata;
            end else begin
                ls_rdata <= ls_rdata;
            end
            if (cap_s && !sel_ls_r) begin
                if_rdata <= mem_rdata;
            end else begin
                if_rdata <= if_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: transaction-level reference model plus behavioural memory.
module tb_mem_bus_arbiter;

    localparam int MEM_LAT    = 3;
    localparam int STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic        mem_en, mem_we, busy;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h00A0_0093;
        return 32'h1000_0000 ^ (i * 32'h0101_0103);
    endfunction

    // Behavioural single-port memory with MEM_LAT read latency
    logic [31:0] mem_arr [256];
    logic [31:0] pd [MEM_LAT];
    logic        pv [MEM_LAT];
    logic [31:0] junk;
    logic        mem_init_done;
    always @(posedge sys_clk) begin
        junk  <= $urandom;
        pv[0] <= (mem_en === 1'b1) && (mem_we === 1'b0);
        pd[0] <= mem_arr[mem_addr[9:2]];
        for (int i = 1; i < MEM_LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
        if (mem_init_done !== 1'b1) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
            mem_init_done <= 1'b1;
        end else if (mem_en === 1'b1 && mem_we === 1'b1) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem_arr[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end
    assign mem_rdata = (pv[MEM_LAT-1] === 1'b1) ? pd[MEM_LAT-1] : junk;

    // ---------------- reference model and monitor ----------------
    typedef struct { int cyc; logic [31:0] data; } rsp_t;
    rsp_t        ls_q[$];
    rsp_t        if_q[$];
    logic [31:0] ref_mem [256];
    logic [31:0] exp_ls_rdata, exp_if_rdata;
    logic [31:0] lat_addr, lat_wdata;
    logic [3:0]  lat_be;
    logic        lat_we;
    bit          pred_ls, pred_if, started, rst_prev;
    int          cyc = 0, sample_from = 0, last_busy = -1, starve = 0, if_gnt_count = 0;

    always @(negedge sys_clk) begin
        rsp_t r;
        bit   ev;
        int   idx;
        cyc++;
        if (started) begin
            if (rst_prev) begin
                chk("rst_mem_we", mem_we, 0);
                chk("rst_mem_be", mem_be, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_wdata", mem_wdata, 0);
            end
            chk("ls_gnt", ls_gnt, pred_ls);
            chk("if_gnt", if_gnt, pred_if);
            chk("mem_en", mem_en, pred_ls | pred_if);
            if (if_gnt === 1'b1) if_gnt_count++;
            if (pred_ls || pred_if) begin
                idx = int'(lat_addr[9:2]);
                chk("mem_addr", mem_addr, lat_addr);
                chk("mem_we", mem_we, lat_we);
                chk("mem_be", mem_be, lat_we ? lat_be : 4'hF);
                if (lat_we) begin
                    chk("mem_wdata", mem_wdata, lat_wdata);
                    for (int b = 0; b < 4; b++)
                        if (lat_be[b]) ref_mem[idx][8*b +: 8] = lat_wdata[8*b +: 8];
                    last_busy   = cyc;
                    sample_from = cyc + 1;
                end else begin
                    r.cyc  = cyc + MEM_LAT + 1;
                    r.data = ref_mem[idx];
                    if (pred_ls) ls_q.push_back(r);
                    else         if_q.push_back(r);
                    last_busy   = cyc + MEM_LAT + 1;
                    sample_from = last_busy;
                end
            end
            ev = (ls_q.size() > 0) && (ls_q[0].cyc == cyc);
            chk("ls_rvalid", ls_rvalid, ev);
            if (ev) begin exp_ls_rdata = ls_q[0].data; void'(ls_q.pop_front()); end
            chk("ls_rdata", ls_rdata, exp_ls_rdata);
            ev = (if_q.size() > 0) && (if_q[0].cyc == cyc);
            chk("if_rvalid", if_rvalid, ev);
            if (ev) begin exp_if_rdata = if_q[0].data; void'(if_q.pop_front()); end
            chk("if_rdata", if_rdata, exp_if_rdata);
            chk("busy", busy, cyc <= last_busy);
        end
        pred_ls = 1'b0;
        pred_if = 1'b0;
        if (sys_rst === 1'b1) begin
            if (!started) for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
            started      = 1'b1;
            rst_prev     = 1'b1;
            ls_q.delete();
            if_q.delete();
            exp_ls_rdata = 32'h0;
            exp_if_rdata = 32'h0;
            last_busy    = -1;
            sample_from  = cyc + 1;
            starve       = 0;
        end else if (started) begin
            rst_prev = 1'b0;
            if (if_req !== 1'b1) starve = 0;
            if (cyc >= sample_from && (ls_req === 1'b1 || if_req === 1'b1)) begin
                if (ls_req === 1'b1 && !(GUARD && if_req === 1'b1 && starve == STARVE_MAX)) begin
                    pred_ls   = 1'b1;
                    lat_addr  = ls_addr;
                    lat_we    = ls_we;
                    lat_be    = ls_be;
                    lat_wdata = ls_wdata;
                    if (if_req === 1'b1) starve++;
                end else begin
                    pred_if  = 1'b1;
                    lat_addr = if_addr;
                    lat_we   = 1'b0;
                    starve   = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge sys_clk); #1; end
    endtask

    task automatic wait_gnt(input bit is_ls);
        int n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (((is_ls ? ls_gnt : if_gnt) !== 1'b1) && n < 400);
        if (n >= 400) begin
            n_chk++;
            n_fail++;
            $display("FAIL gnt_timeout: no %s grant after %0d cycles", is_ls ? "ls" : "if", n);
        end
        @(posedge sys_clk); #1;
    endtask

    task automatic wait_rvalid(input bit is_ls);
        int n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (((is_ls ? ls_rvalid : if_rvalid) !== 1'b1) && n < 50);
        if (n >= 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL rvalid_timeout: no %s rvalid after %0d cycles", is_ls ? "ls" : "if", n);
        end
        @(posedge sys_clk); #1;
    endtask

    task automatic do_ls(input logic we, input logic [3:0] be, input logic [31:0] a,
                         input logic [31:0] d, input bit keep);
        ls_we = we; ls_be = be; ls_addr = a; ls_wdata = d; ls_req = 1'b1;
        wait_gnt(1'b1);
        if (!keep) ls_req = 1'b0;
    endtask

    task automatic do_if(input logic [31:0] a);
        if_addr = a; if_req = 1'b1;
        wait_gnt(1'b0);
        if_req = 1'b0;
    endtask

    task automatic do_reset(input int n);
        sys_rst = 1'b1;
        idle(n);
        sys_rst = 1'b0;
    endtask

    initial begin
        int win;
        sys_rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; ls_req = 1'b0; ls_we = 1'b0;
        ls_be = 4'h0; ls_addr = 32'h0; ls_wdata = 32'h0;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        idle(2);

        // single fetch of the preloaded instruction word
        do_if(32'h0000_0010);
        wait_rvalid(1'b0);
        chk("fetch_data", if_rdata, 32'h00A0_0093);

        // partial LSU write, then read it back
        do_ls(1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
        @(negedge sys_clk);
        chk("write_then_idle", busy, 1'b0);
        @(posedge sys_clk); #1;
        do_ls(1'b0, 4'h0, 32'h0000_0100, 32'h0, 1'b0);
        wait_rvalid(1'b1);
        chk("write_readback", ls_rdata, {init_word(64)[31:16], 16'hBEEF});
        idle(2);

        // collision: LSU first, then fetch
        fork
            do_ls(1'b0, 4'h0, 32'h0000_0020, 32'h0, 1'b0);
            do_if(32'h0000_0024);
        join
        idle(8);

        // starvation: continuous LSU reads against a waiting fetch
        fork
            begin
                win = if_gnt_count;
                for (int k = 0; k < 10; k++)
                    do_ls(1'b0, 4'h0, 32'h0000_0040 + 32'(k * 4), 32'h0, k < 9);
                chk("starve_if_gnts", if_gnt_count - win, GUARD ? 1 : 0);
            end
            do_if(32'h0000_0080);
        join
        idle(8);

        // reset in the middle of a fetch WAIT, then a fresh fetch
        do_if(32'h0000_0014);
        do_reset(2);
        idle(1);
        do_if(32'h0000_0010);
        wait_rvalid(1'b0);
        chk("post_reset_fetch", if_rdata, 32'h00A0_0093);

        // randomized concurrent traffic
        fork
            for (int k = 0; k < 30; k++) begin
                idle($urandom_range(0, 3));
                do_ls(1'($urandom_range(0, 1)), 4'($urandom), {22'h0, 8'($urandom), 2'b00},
                      $urandom, 1'b0);
            end
            for (int k = 0; k < 30; k++) begin
                idle($urandom_range(0, 3));
                do_if({22'h0, 8'($urandom), 2'b00});
            end
        join
        idle(12);
        chk("drain", ls_q.size() + if_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares one single-port synchronous memory between the instruction-fetch stage and the load/store path of the 3-stage RISC-V core. Each requester uses a req/gnt handshake and receives a registered read-response pulse. The arbiter gives data accesses priority and can optionally include an anti-starvation guard for fetch. It sits between `instruction_fetch`/LSU and the memory macro inside `open_risc_v`.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- MEM_LAT, 1, memory read latency in cycles, ≥1
- STARVE_MAX, 4, consecutive LSU grants allowed while fetch waits (guard only), ≥1

- sys_clk  in  1  clock
- sys_rst  in  1  reset; one clock, synchronous, active-high
- if_req  in  1  fetch read request, held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request issued to memory (1-cycle pulse)
- if_rvalid  out  1  fetch data valid (1-cycle pulse)
- if_rdata  out  DATA_W  fetch read data
- ls_req  in  1  LSU request, held until ls_gnt
- ls_we  in  1  1 = write, 0 = read
- ls_be  in  DATA_W/8  write byte enables
- ls_addr  in  ADDR_W  LSU address
- ls_wdata  in  DATA_W  LSU write data
- ls_gnt  out  1  LSU request issued (1-cycle pulse)
- ls_rvalid  out  1  LSU read data valid (1-cycle pulse)
- ls_rdata  out  DATA_W  LSU read data
- mem_en, mem_we  out  1  memory strobe and write enable
- mem_be  out  DATA_W/8  byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory data, valid MEM_LAT cycles after the mem_en cycle
- busy  out  1  high when the FSM is not in IDLE

## Operation
- FSM states:
  - IDLE and RESP sample requests.
  - ISSUE drives memory.
  - WAIT counts read latency.
- Arbitration happens at the end of an IDLE or RESP cycle:
  - If ls_req is high, the LSU wins; otherwise if_req wins.
  - Winner's address, we, be and wdata are latched, and the next state is ISSUE.
  - With no request: RESP→IDLE, IDLE→IDLE.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_addr/mem_we/mem_wdata come from the latch.
  - mem_be = latched be for writes, all-ones for reads.
  - Winner's gnt=1.
  - Write: next state is IDLE; no rvalid is produced.
  - Read: next state is WAIT.
- WAIT: lasts MEM_LAT cycles. At the end of the last WAIT cycle, mem_rdata is captured into the winner's rdata register; next state is RESP.
- RESP: winner's rvalid=1 for 1 cycle; arbitration is sampled as in IDLE.
- ISSUE and WAIT never sample requests, so a held req is never granted twice.
- rdata registers hold their last value until the next capture for that port.
- Fetch accesses are always reads; if_rdata and ls_rdata are separate registers.
- Addresses pass through unchanged; there is no alignment check.

## Timing
- Reset: on the first sys_clk edge with sys_rst=1:
  - State goes to IDLE.
  - All outputs go to 0: gnt, rvalid, mem_*, busy, rdata registers.
  - Latches and the starvation counter clear.
  - Any in-flight transaction is abandoned; no rvalid ever follows it.
- Read, request sampled in cycle T0 (IDLE):
  - ISSUE and gnt in T1.
  - WAIT in T2..T1+MEM_LAT.
  - rvalid in T2+MEM_LAT.
  - A request sampled in RESP issues in the following cycle, so back-to-back read period = MEM_LAT+2 cycles.
- Write, sampled in T0: ISSUE and gnt in T1, IDLE in T2, next ISSUE no earlier than T3.
- Simultaneous if_req and ls_req: LSU first; fetch is issued in the cycle after the LSU transaction ends (after LSU RESP for a read, or the cycle after IDLE for a write).
- A req dropped before gnt is simply not sampled; this is legal.
- All outputs are registered, except busy, which is decoded from state.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A counter increments on each LSU grant made while if_req=1.
  - The counter clears on a fetch grant or whenever if_req=0.
  - When count == STARVE_MAX and if_req=1, the next arbitration goes to fetch even if ls_req=1.
- Undefined: strict LSU priority; fetch can starve indefinitely while ls_req stays high.

## Test plan
- Reset mid-read:
  - Stimulus: MEM_LAT=3; assert sys_rst for 2 cycles during WAIT.
  - Response: all outputs 0 after the first reset edge, no if_rvalid, busy=0; a fresh fetch after release completes normally.
- Single fetch:
  - Stimulus: MEM_LAT=1; if_req at addr 0x10 in T0; memory returns 0x00A00093.
  - Response: mem_en/if_gnt/mem_addr=0x10 in T1; if_rvalid=1 with if_rdata=0x00A00093 in T3.
- LSU write:
  - Stimulus: ls_we=1, ls_be=4'b0011, addr 0x100, wdata 0xDEADBEEF.
  - Response: in T1, mem_en=1, mem_we=1, mem_be=4'b0011, mem_wdata=0xDEADBEEF, ls_gnt=1; no ls_rvalid; IDLE in T2.
- Collision:
  - Stimulus: MEM_LAT=1; if_req and ls_req (read) both rise in T0.
  - Response: ls_gnt in T1, ls_rvalid in T3, if_gnt in T4, if_rvalid in T6.
- Starvation:
  - Stimulus: ls_req (reads) and if_req held continuously; STARVE_MAX=4.
  - Response with ARB_STARVE_GUARD_EN: 4 LSU grants, then if_gnt, then LSU resumes.
  - Response without it: if_gnt is never asserted.
- Back-to-back reads:
  - Stimulus: MEM_LAT=3; ls_req held continuously.
  - Response: ls_gnt and ls_rvalid each pulse every 5 cycles; each ls_rdata equals the mem_rdata captured for that access.
